// File: rtl/race_controller.sv
// Race sequencer: start-light countdown, checkpoint/lap validation and lap-timer
// command pulses. All outputs come straight from registers.
module race_controller #(
    parameter int NUM_LAPS   = 3,
    parameter int TICK_DIV   = 650000,
    parameter int STEP_TICKS = 100
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       finish_line,
    input  logic [3:0] checkpoint,
    input  logic       max_time_exceeded,
    output logic       timer_rst,
    output logic       timer_start,
    output logic       timer_stop,
    output logic       timer_lap_finished,
    output logic       checkpoints_passed,
    output logic [2:0] lights,
    output logic [3:0] lap_count,
    output logic       racing,
    output logic       paused,
    output logic       race_over,
    output logic       dnf
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_COUNTDOWN, S_RACING, S_PAUSED, S_FINISHED} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [SW-1:0] step_reg, step_next;
    logic [2:0]    lights_reg, lights_next;
    logic [3:0]    lap_count_reg, lap_count_next;
    logic [3:0]    mask_reg, mask_next;
    logic [1:0]    phase_reg, phase_next;
    logic          finishing_reg, finishing_next;
    logic          race_over_reg, race_over_next;
    logic          dnf_reg, dnf_next;
    logic          timer_rst_reg, timer_rst_next;
    logic          timer_start_reg, timer_start_next;
    logic          timer_stop_reg, timer_stop_next;
    logic          lap_fin_reg, lap_fin_next;
    logic          cp_passed_reg, cp_passed_next;
    logic          racing_reg, racing_next;
    logic          paused_reg, paused_next;
    logic          fin_prev_reg;

    logic       fin_edge;
    logic       lap_idle;
    logic       cp_window;
    logic [3:0] cp_accept;

    assign fin_edge  = finish_line & ~fin_prev_reg;
    assign lap_idle  = (phase_reg == 2'd0);
    assign cp_window = (state_reg == S_RACING) && lap_idle && !fin_edge;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cp
            assign cp_accept[gi] = checkpoint[gi] & cp_window;
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        presc_next       = presc_reg;
        step_next        = step_reg;
        lights_next      = lights_reg;
        lap_count_next   = lap_count_reg;
        mask_next        = mask_reg;
        phase_next       = phase_reg;
        finishing_next   = finishing_reg;
        race_over_next   = race_over_reg;
        dnf_next         = dnf_reg;
        timer_rst_next   = 1'b0;
        timer_start_next = 1'b0;
        timer_stop_next  = 1'b0;
        lap_fin_next     = 1'b0;

        // Lap window: phase 1 = N+1, phase 2 = N+2; the mask clears leaving N+2.
        case (phase_reg)
            2'd1:    phase_next = 2'd2;
            2'd2:    begin
                phase_next = 2'd0;
                mask_next  = '0;
            end
            default: ;
        endcase

        case (state_reg)
            S_IDLE, S_FINISHED: begin
                if (btn_start) begin
                    timer_rst_next = 1'b1;
                    lap_count_next = '0;
                    mask_next      = '0;
                    phase_next     = 2'd0;
                    finishing_next = 1'b0;
                    race_over_next = 1'b0;
                    dnf_next       = 1'b0;
                    presc_next     = '0;
                    step_next      = '0;
                    lights_next    = 3'b000;
                    state_next     = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (presc_reg == PW'(TICK_DIV - 1)) begin
                    presc_next = '0;
                    if (step_reg == SW'(STEP_TICKS - 1)) begin
                        step_next = '0;
                        if (lights_reg == 3'b111) begin
                            lights_next      = 3'b000;
                            timer_start_next = 1'b1;
                            state_next       = S_RACING;
                        end else begin
                            lights_next = {lights_reg[1:0], 1'b1};
                        end
                    end else begin
                        step_next = step_reg + SW'(1);
                    end
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
            end
            S_RACING: begin
                if (lap_idle)
                    mask_next = mask_reg | cp_accept;
                if (fin_edge && lap_idle) begin
                    phase_next     = 2'd1;
                    lap_fin_next   = 1'b1;
                    finishing_next = 1'b0;
                    if ((&mask_reg) && (lap_count_reg < 4'(NUM_LAPS))) begin
                        lap_count_next = lap_count_reg + 4'd1;
                        finishing_next = ((lap_count_reg + 4'd1) == 4'(NUM_LAPS));
                    end
                end else if (phase_reg == 2'd1 && finishing_reg) begin
                    finishing_next  = 1'b0;
                    timer_stop_next = 1'b1;
                    race_over_next  = 1'b1;
                    state_next      = S_FINISHED;
                end else if (max_time_exceeded) begin
                    dnf_next        = 1'b1;
                    timer_stop_next = 1'b1;
                    state_next      = S_FINISHED;
                end else if (btn_pause && lap_idle) begin
                    timer_stop_next = 1'b1;
                    state_next      = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (btn_pause) begin
                    timer_start_next = 1'b1;
                    state_next       = S_RACING;
                end
            end
            default: state_next = S_IDLE;
        endcase

        cp_passed_next = &mask_next;
        racing_next    = (state_next == S_RACING);
        paused_next    = (state_next == S_PAUSED);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            presc_reg       <= '0;
            step_reg        <= '0;
            lights_reg      <= 3'b000;
            lap_count_reg   <= '0;
            mask_reg        <= '0;
            phase_reg       <= 2'd0;
            finishing_reg   <= 1'b0;
            race_over_reg   <= 1'b0;
            dnf_reg         <= 1'b0;
            timer_rst_reg   <= 1'b0;
            timer_start_reg <= 1'b0;
            timer_stop_reg  <= 1'b0;
            lap_fin_reg     <= 1'b0;
            cp_passed_reg   <= 1'b0;
            racing_reg      <= 1'b0;
            paused_reg      <= 1'b0;
            fin_prev_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            presc_reg       <= presc_next;
            step_reg        <= step_next;
            lights_reg      <= lights_next;
            lap_count_reg   <= lap_count_next;
            mask_reg        <= mask_next;
            phase_reg       <= phase_next;
            finishing_reg   <= finishing_next;
            race_over_reg   <= race_over_next;
            dnf_reg         <= dnf_next;
            timer_rst_reg   <= timer_rst_next;
            timer_start_reg <= timer_start_next;
            timer_stop_reg  <= timer_stop_next;
            lap_fin_reg     <= lap_fin_next;
            cp_passed_reg   <= cp_passed_next;
            racing_reg      <= racing_next;
            paused_reg      <= paused_next;
            fin_prev_reg    <= finish_line;
        end
    end

    assign timer_rst          = timer_rst_reg;
    assign timer_start        = timer_start_reg;
    assign timer_stop         = timer_stop_reg;
    assign timer_lap_finished = lap_fin_reg;
    assign checkpoints_passed = cp_passed_reg;
    assign lights             = lights_reg;
    assign lap_count          = lap_count_reg;
    assign racing             = racing_reg;
    assign paused             = paused_reg;
    assign race_over          = race_over_reg;
    assign dnf                = dnf_reg;
endmodule

// File: tb/tb_race_controller.sv
// Randomized race scenarios; a race-level model predicts every visible output event
// (pulses, light changes, checkpoint flag changes) which a monitor scores in order.
module tb_race_controller;
    localparam int NL = 2;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_pause = 1'b0, finish_line = 1'b0, max_time_exceeded = 1'b0;
    logic [3:0] checkpoint = 4'b0000;
    logic       timer_rst, timer_start, timer_stop, timer_lap_finished, checkpoints_passed;
    logic [2:0] lights;
    logic [3:0] lap_count;
    logic       racing, paused, race_over, dnf;

    race_controller #(.NUM_LAPS(NL), .TICK_DIV(2), .STEP_TICKS(2)) dut (
        .pclk(pclk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
        .finish_line(finish_line), .checkpoint(checkpoint),
        .max_time_exceeded(max_time_exceeded),
        .timer_rst(timer_rst), .timer_start(timer_start), .timer_stop(timer_stop),
        .timer_lap_finished(timer_lap_finished), .checkpoints_passed(checkpoints_passed),
        .lights(lights), .lap_count(lap_count), .racing(racing), .paused(paused),
        .race_over(race_over), .dnf(dnf)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        int         cyc;
        logic [3:0] pulses;   // {timer_rst, timer_start, timer_stop, timer_lap_finished}
        logic [2:0] lights;
        logic       cp;
        logic [3:0] laps;
        logic       racing;
        logic       paused;
        logic       over;
        logic       dnf;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  act_ev, exp_ev;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic [2:0] prev_lights = 3'b000;
    logic       prev_cp = 1'b0;

    // Race-level model
    int         m_laps = 0;
    logic [3:0] m_mask = 4'b0000;
    bit         m_racing = 1'b0;
    bit         m_over = 1'b0;
    bit         m_dnf = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic string fmt(ev_t e);
        return $sformatf("cyc=%0d pulses=%b lights=%b cp=%b laps=%0d racing=%b paused=%b over=%b dnf=%b",
                         e.cyc, e.pulses, e.lights, e.cp, e.laps, e.racing, e.paused, e.over, e.dnf);
    endfunction

    always @(negedge pclk) begin
        if (mon_en) begin
            act_ev.cyc    = cyc;
            act_ev.pulses = {timer_rst, timer_start, timer_stop, timer_lap_finished};
            act_ev.lights = lights;
            act_ev.cp     = checkpoints_passed;
            act_ev.laps   = lap_count;
            act_ev.racing = racing;
            act_ev.paused = paused;
            act_ev.over   = race_over;
            act_ev.dnf    = dnf;
            if (act_ev.pulses != 4'b0000 || lights != prev_lights || checkpoints_passed != prev_cp) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got %s required no event", fmt(act_ev));
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (act_ev !== exp_ev) begin
                        failures++;
                        $display("FAIL event: got %s required %s", fmt(act_ev), fmt(exp_ev));
                    end else begin
                        $display("ok   event: %s", fmt(act_ev));
                    end
                end
            end
        end
        prev_lights = lights;
        prev_cp     = checkpoints_passed;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [2:0] l, input logic cp,
                        input int laps, input logic r, input logic pa, input logic o, input logic d);
        ev_t e;
        e.cyc = c; e.pulses = p; e.lights = l; e.cp = cp; e.laps = 4'(laps);
        e.racing = r; e.paused = pa; e.over = o; e.dnf = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {16'd0, timer_rst, timer_start, timer_stop, timer_lap_finished, checkpoints_passed,
                lights, lap_count, racing, paused, race_over, dnf};
    endfunction

    // Start from IDLE/FINISHED; lights step every 4 cycles, racing begins 16 cycles after entry.
    task automatic do_start();
        int k;
        k = cyc;
        btn_start = 1'b1;
        push(k + 1,  4'b1000, 3'b000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(k + 5,  4'b0000, 3'b001, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(k + 9,  4'b0000, 3'b011, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(k + 13, 4'b0000, 3'b111, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(k + 17, 4'b0100, 3'b000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        while (cyc < k + 17) begin
            btn_start = ($urandom_range(3) == 0);
            btn_pause = ($urandom_range(3) == 0);
            tick();
        end
        btn_start = 1'b0;
        btn_pause = 1'b0;
        m_laps = 0; m_mask = 4'b0000; m_racing = 1'b1; m_over = 1'b0; m_dnf = 1'b0;
    endtask

    task automatic do_checkpoint(input logic [3:0] v);
        logic [3:0] nm;
        nm = m_mask | v;
        if ((&nm) && !(&m_mask))
            push(cyc + 1, 4'b0000, 3'b000, 1'b1, m_laps, 1'b1, 1'b0, 1'b0, 1'b0);
        m_mask = nm;
        checkpoint = v;
        tick();
        checkpoint = 4'b0000;
    endtask

    task automatic do_lap(input bit with_pause);
        int   k, nl;
        logic full;
        k    = cyc;
        full = &m_mask;
        nl   = m_laps + (full ? 1 : 0);
        finish_line = 1'b1;
        btn_pause   = with_pause;
        push(k + 1, 4'b0001, 3'b000, full, nl, 1'b1, 1'b0, 1'b0, 1'b0);
        if (full && nl == NL) begin
            push(k + 2, 4'b0010, 3'b000, 1'b1, nl, 1'b0, 1'b0, 1'b1, 1'b0);
            push(k + 3, 4'b0000, 3'b000, 1'b0, nl, 1'b0, 1'b0, 1'b1, 1'b0);
        end else if (full) begin
            push(k + 3, 4'b0000, 3'b000, 1'b0, nl, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        repeat (2) begin
            checkpoint = 4'($urandom_range(15));
            btn_pause  = ($urandom_range(2) == 0);
            tick();
        end
        checkpoint = 4'b0000;
        btn_pause  = 1'b0;
        repeat ($urandom_range(2)) tick();
        finish_line = 1'b0;
        tick();
        m_laps = nl;
        m_mask = 4'b0000;
        if (full && nl == NL) begin
            m_racing = 1'b0;
            m_over   = 1'b1;
        end
    endtask

    task automatic do_pause();
        int k;
        k = cyc;
        btn_pause = 1'b1;
        push(k + 1, 4'b0010, 3'b000, &m_mask, m_laps, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        btn_pause = 1'b0;
        repeat ($urandom_range(6, 3)) begin
            checkpoint  = 4'($urandom_range(15));
            btn_start   = ($urandom_range(3) == 0);
            finish_line = $urandom_range(1);
            tick();
        end
        checkpoint = 4'b0000;
        btn_start  = 1'b0;
        btn_pause  = 1'b1;
        k = cyc;
        push(k + 1, 4'b0100, 3'b000, &m_mask, m_laps, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        btn_pause   = 1'b0;
        finish_line = 1'b0;
        tick();
    endtask

    task automatic do_maxtime();
        max_time_exceeded = 1'b1;
        push(cyc + 1, 4'b0010, 3'b000, &m_mask, m_laps, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        max_time_exceeded = 1'b0;
        m_racing = 1'b0;
        m_dnf    = 1'b1;
        tick();
    endtask

    initial begin
        int k, ops, r;
        repeat (3) tick();
        check("reset_outputs", all_outputs(), 32'd0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Scripted race: invalid lap, lap+pause collision, pause/resume, finishing lap.
        do_start();
        do_checkpoint(4'b0011);
        do_lap(1'b0);
        do_checkpoint(4'b1111);
        do_lap(1'b1);
        do_pause();
        do_checkpoint(4'b0101);
        do_checkpoint(4'b0101);
        do_checkpoint(4'b1010);
        do_lap(1'b0);
        repeat (3) tick();
        // Restart from FINISHED, then a did-not-finish.
        do_start();
        do_checkpoint(4'b1111);
        do_maxtime();
        repeat (2) tick();

        for (int race = 0; race < 6; race++) begin
            do_start();
            ops = 0;
            while (m_racing && ops < 30) begin
                r = $urandom_range(9);
                if (r <= 3)      do_checkpoint(4'($urandom_range(15)));
                else if (r <= 6) do_lap($urandom_range(2) == 0);
                else if (r == 7) do_pause();
                else if (r == 9 && ops > 12) do_maxtime();
                else             repeat ($urandom_range(3)) tick();
                ops++;
            end
            if (m_racing) do_maxtime();
            repeat ($urandom_range(4, 1)) tick();
        end

        // Reset in the middle of the countdown.
        repeat (6) tick();
        mon_en = 1'b0;
        k = cyc;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        while (cyc < k + 10) tick();
        check("countdown_lights_before_rst", {29'd0, lights}, 32'd3);
        rst = 1'b1;
        tick();
        check("rst_mid_countdown", all_outputs(), 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        check("idle_after_rst", all_outputs(), 32'd0);
        mon_en = 1'b1;

        do_start();
        do_checkpoint(4'b1111);
        do_lap(1'b0);
        repeat (8) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (80000) @(posedge pclk);
        failures++;
        $display("FAIL watchdog: got timeout required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/race_controller.md
RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 Parameter NUM_LAPS, default 3, range 1..15: valid laps needed to finish the race.
REQ-002 Parameter TICK_DIV, default 650000: pclk cycles per 0.01 s tick.
REQ-003 Parameter STEP_TICKS, default 100: ticks per countdown light step.
REQ-004 pclk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 btn_start  in  1  single-cycle pulse; request a new race.
REQ-007 btn_pause  in  1  single-cycle pulse; toggle pause.
REQ-008 finish_line  in  1  level; car is over the finish line.
REQ-009 checkpoint  in  4  single-cycle pulses; bit i means checkpoint i was crossed.
REQ-010 max_time_exceeded  in  1  from lap timer.
REQ-011 timer_rst, timer_start, timer_stop, timer_lap_finished  out  1 each  single-cycle command pulses to lap timer.
REQ-012 checkpoints_passed  out  1  all four checkpoint mask bits set.
REQ-013 lights  out  3  start-light pattern.
REQ-014 lap_count  out  4  valid laps completed.
REQ-015 racing, paused, race_over, dnf  out  1 each  status levels.

Function
REQ-016 States: IDLE, COUNTDOWN, RACING, PAUSED, FINISHED. All outputs are registered.
REQ-017 IDLE or FINISHED plus btn_start: pulse timer_rst for 1 cycle; clear lap_count, mask, race_over and dnf; enter COUNTDOWN.
REQ-018 COUNTDOWN: a prescaler produces a tick every TICK_DIV cycles, and a step counter counts STEP_TICKS ticks per step.
REQ-019 Light sequence: lights=000 on entry, then 001, 011, 111 on successive steps; at the 4th step lights=000, pulse timer_start, enter RACING.
REQ-020 In COUNTDOWN, btn_pause and btn_start are ignored.
REQ-021 RACING: a checkpoint[i] pulse sets mask bit i; repeated pulses have no further effect. checkpoints_passed = &mask.
REQ-022 RACING: a finish_line rising edge (0->1, sampled register) detected in cycle N asserts timer_lap_finished in cycle N+1.
REQ-023 Mask and checkpoints_passed are held through cycle N+2, then the mask clears at the end of N+2.
REQ-024 Checkpoint pulses during N..N+2 are ignored.
REQ-025 If the mask was full at N, lap_count increments in N+1; otherwise the lap is invalid and lap_count is unchanged.
REQ-026 If the increment makes lap_count equal NUM_LAPS: pulse timer_stop in N+2, set race_over, enter FINISHED.
REQ-027 In RACING, a finish_line edge and btn_pause in the same cycle: the finish edge is processed and the pause is dropped. timer_stop and timer_lap_finished are never asserted together.
REQ-028 RACING plus btn_pause, with no lap sequence in flight (N..N+2): pulse timer_stop and enter PAUSED. A pause during N..N+2 is dropped.
REQ-029 PAUSED plus btn_pause: pulse timer_start and enter RACING.
REQ-030 In PAUSED, checkpoint, finish_line and btn_start are ignored, and the finish edge detector keeps tracking the level.
REQ-031 RACING and max_time_exceeded high: set dnf, pulse timer_stop, enter FINISHED.
REQ-032 racing=1 only in RACING. paused=1 only in PAUSED. race_over and dnf hold until the next btn_start or rst.
REQ-033 lap_count saturates at NUM_LAPS. Prescaler and step counter are zeroed on COUNTDOWN entry.

Reset
REQ-034 While rst=1, the next edge forces: state IDLE; lights=000; lap_count=0; mask=0; all pulses, racing, paused, race_over and dnf = 0; prescaler, step counter and edge register = 0. This applies regardless of current state, including mid-countdown or mid-lap sequence.

Verification (TICK_DIV=2, STEP_TICKS=2, NUM_LAPS=2)
REQ-035 btn_start in IDLE -> timer_rst 1 cycle; lights 001/011/111 at 4-cycle spacing; then lights=000, timer_start pulse, racing=1.
REQ-036 checkpoint=1111 then finish_line 0->1 at cycle N -> timer_lap_finished at N+1, lap_count=1 at N+1, checkpoints_passed=1 through N+2, then 0.
REQ-037 Only checkpoint=0011 then finish edge -> lap_finished pulse, checkpoints_passed=0, lap_count stays 0.
REQ-038 Second valid lap -> lap_count=2, timer_stop at N+2, race_over=1, state FINISHED; later btn_start -> timer_rst, lap_count=0.
REQ-039 btn_pause and finish edge in the same cycle -> lap_finished only, no timer_stop; btn_pause later -> timer_stop, paused=1; btn_pause again -> timer_start.
REQ-040 max_time_exceeded=1 in RACING -> dnf=1, timer_stop pulse; rst mid-COUNTDOWN -> IDLE, lights=000, all outputs 0.
